// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter and sequencer in front of
// the single DATA_RAM access unit. Requester 0 is the load/store stage,
// requester 1 the debug/DMA port. One transaction is in flight at a time:
// capture operands (ack), pulse ram_start, wait for ram_done, return res.
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   reqN, op1_N, op2_N, imm_N,
//   part_N, mode1_N, mode2_N  requester N request (level) and operands
//   ackN                      one-cycle pulse: requester N operands captured
//   doneN, resN               one-cycle pulse: resN valid (resN holds after)
//   ram_start, ram_op1/op2/imm,
//   ram_part/mode1/mode2      command and operands toward DATA_RAM
//   ram_done, ram_res         completion and result from DATA_RAM
//   busy                      high whenever the sequencer is not idle
//   err                       watchdog timeout pulse
//
// Optional feature: define RAM_WDOG_EN to enable a WAIT-state watchdog of
// TIMEOUT_CYC cycles. On expiry err pulses, res<owner> becomes all-ones and
// done<owner> still pulses. Without the macro WAIT waits forever, err = 0.
module ram_arbiter #(
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [DW-1:0] op1_0,
  input  logic [DW-1:0] op2_0,
  input  logic [DW-1:0] imm_0,
  input  logic [1:0]    part_0,
  input  logic [1:0]    mode1_0,
  input  logic [2:0]    mode2_0,
  output logic          ack0,
  output logic          done0,
  output logic [DW-1:0] res0,
  input  logic          req1,
  input  logic [DW-1:0] op1_1,
  input  logic [DW-1:0] op2_1,
  input  logic [DW-1:0] imm_1,
  input  logic [1:0]    part_1,
  input  logic [1:0]    mode1_1,
  input  logic [2:0]    mode2_1,
  output logic          ack1,
  output logic          done1,
  output logic [DW-1:0] res1,
  output logic          ram_start,
  output logic [DW-1:0] ram_op1,
  output logic [DW-1:0] ram_op2,
  output logic [DW-1:0] ram_imm,
  output logic [1:0]    ram_part,
  output logic [1:0]    ram_mode1,
  output logic [2:0]    ram_mode2,
  input  logic          ram_done,
  input  logic [DW-1:0] ram_res,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          owner_q, owner_d;
  logic [DW-1:0] op1_q, op1_d, op2_q, op2_d, imm_q, imm_d;
  logic [1:0]    part_q, part_d, mode1_q, mode1_d;
  logic [2:0]    mode2_q, mode2_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d, start_q, start_d;
  logic          done0_q, done0_d, done1_q, done1_d, err_q, err_d;
  logic [DW-1:0] res0_q, res0_d, res1_q, res1_d;
  logic          any_req, winner, timeout;

  // Round robin: the requester that did not win last time has priority.
  assign any_req = req0 | req1;
  assign winner  = last_grant_q ? ~req0 : req1;

`ifdef RAM_WDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wdog_q, wdog_d;

  // Cleared while in ISSUE so it reads 0 in the first WAIT cycle.
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == S_ISSUE)     wdog_d = '0;
    else if (state_q == S_WAIT) wdog_d = wdog_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wdog_q <= '0;
    else      wdog_q <= wdog_d;
  end

  // Fires in the TIMEOUT_CYC-th WAIT cycle; a real ram_done has priority.
  assign timeout = (state_q == S_WAIT) && (wdog_q == CW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_req) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (ram_done || timeout) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    imm_d        = imm_q;
    part_d       = part_q;
    mode1_d      = mode1_q;
    mode2_d      = mode2_q;
    res0_d       = res0_q;
    res1_d       = res1_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    start_d      = 1'b0;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    err_d        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d      = winner;
          last_grant_d = winner;
          ack0_d       = ~winner;
          ack1_d       = winner;
          op1_d        = winner ? op1_1   : op1_0;
          op2_d        = winner ? op2_1   : op2_0;
          imm_d        = winner ? imm_1   : imm_0;
          part_d       = winner ? part_1  : part_0;
          mode1_d      = winner ? mode1_1 : mode1_0;
          mode2_d      = winner ? mode2_1 : mode2_0;
        end
      end
      S_ISSUE: start_d = 1'b1;
      S_WAIT: begin
        if (ram_done || timeout) begin
          if (owner_q) res1_d = ram_done ? ram_res : '1;
          else         res0_d = ram_done ? ram_res : '1;
          done0_d = ~owner_q;
          done1_d = owner_q;
          err_d   = ~ram_done;
        end
      end
      default: ;
    endcase
  end

  // NOTE: all datapath registers, including operands and results, are reset
  // so every output reads 0 after reset rather than stale data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      imm_q        <= '0;
      part_q       <= '0;
      mode1_q      <= '0;
      mode2_q      <= '0;
      res0_q       <= '0;
      res1_q       <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      start_q      <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      imm_q        <= imm_d;
      part_q       <= part_d;
      mode1_q      <= mode1_d;
      mode2_q      <= mode2_d;
      res0_q       <= res0_d;
      res1_q       <= res1_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      start_q      <= start_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      err_q        <= err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign res0      = res0_q;
  assign res1      = res1_q;
  assign err       = err_q;
  assign ram_start = start_q;
  assign ram_op1   = op1_q;
  assign ram_op2   = op2_q;
  assign ram_imm   = imm_q;
  assign ram_part  = part_q;
  assign ram_mode1 = mode1_q;
  assign ram_mode2 = mode2_q;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single DATA_RAM access unit.
- Requester 0 is the load/store stage; requester 1 is the debug/DMA port.
- Captures one request's operands, issues a one-cycle start pulse to DATA_RAM, waits for its done, and returns res to the requester that owns the transaction. Only one transaction is in flight at a time.

Parameters:
DW, 32, data/address width of op1, op2, imm_data, res
TIMEOUT_CYC, 64, watchdog limit in cycles (used only with RAM_WDOG_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
req0  in  1  requester 0 request, level; held until ack0
op1_0  in  DW  requester 0 op1
op2_0  in  DW  requester 0 op2
imm_0  in  DW  requester 0 imm_data
part_0  in  2  requester 0 use_part
mode1_0  in  2  requester 0 op_mode1
mode2_0  in  3  requester 0 op_mode2
ack0  out  1  one-cycle pulse: requester 0 operands captured
done0  out  1  one-cycle pulse: res0 valid
res0  out  DW  result for requester 0
req1, op1_1, op2_1, imm_1, part_1, mode1_1, mode2_1, ack1, done1, res1: same as the requester 0 set, for requester 1
ram_start  out  1  to DATA_RAM start
ram_op1, ram_op2, ram_imm  out  DW  to DATA_RAM op1/op2/imm_data
ram_part  out  2  to DATA_RAM use_part
ram_mode1  out  2  to DATA_RAM op_mode1
ram_mode2  out  3  to DATA_RAM op_mode2
ram_done  in  1  from DATA_RAM done, one-cycle pulse
ram_res  in  DW  from DATA_RAM res, valid with ram_done
busy  out  1  high whenever state != IDLE
err  out  1  watchdog error pulse (RAM_WDOG_EN only; otherwise tied 0)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, last_grant=1, so requester 0 wins first.
  - All outputs 0, including the ram_* operand registers, res0 and res1.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, choose the winner: the requester other than last_grant wins if it is requesting; otherwise the single requester wins.
  - Register the winner's operands into ram_* and set owner = winner and last_grant = winner.
  - Pulse ack<owner> in the same cycle as capture, then go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE: ram_start=1 for exactly one cycle; go to WAIT.
- WAIT:
  - ram_* operands are held stable until ram_done.
  - On ram_done: latch ram_res into res<owner>; go to RESP.
- RESP: done<owner>=1 for one cycle; go to IDLE.
- Latency:
  - req to ack: 1 cycle (registered).
  - ack to ram_start: 1 cycle.
  - ram_done to done<owner>: 1 cycle.
  - Minimum back-to-back spacing: 4 cycles plus the DATA_RAM latency.
- Simultaneous req0 and req1: alternate strictly; neither requester waits more than one transaction.
- A request arriving during ISSUE, WAIT or RESP is not sampled until IDLE.
- The requester deasserts req on the cycle after ack, unless it issues a new request. A req still high in IDLE is a new request.
- ram_done outside WAIT is ignored, with no state change.
- res0 and res1 hold their last values until overwritten.
- rst asserted mid-transaction aborts immediately to reset values. An in-flight DATA_RAM operation is discarded; DATA_RAM is reset by the same rst.

Optional Feature:
- Macro RAM_WDOG_EN, defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC without ram_done: err pulses one cycle, res<owner> is set to all-ones, and the FSM goes to RESP (done<owner> still pulses).
- Macro not defined: no counter; WAIT waits forever; err is constant 0.

Test Plan:
- Single req0 with op1=0, op2=FFFF_FFFF, imm=1, part=01, mode2=010; model DATA_RAM done 3 cycles after start with res=0000_0001 -> ack0 on cycle 1, ram_start on cycle 2, done0 one cycle after ram_done, res0=0000_0001, req1 side idle.
- req0 and req1 held together for 4 transactions -> grant order 0,1,0,1; each ram_start carries the correct requester's op1 (req0 op1=20, req1 op1=30).
- req1 asserted alone while req0 is in WAIT -> req1 served right after done0, not preempting; ram_op1 stays at req0's value until ram_done.
- Spurious ram_done pulses in IDLE and ISSUE -> no done0/done1, no state change.
- rst low during WAIT -> asynchronously busy=0, ram_start=0, res0=res1=0; next req0 is granted first.
- With RAM_WDOG_EN and TIMEOUT_CYC=8, model never asserts ram_done -> err pulse after 8 WAIT cycles, done0 pulses with res0=FFFF_FFFF, FSM returns to IDLE.
